// File: rtl/motor_ctrl_pkg.sv
// Shared types and constants for the two-motor H-bridge sequencer.
package motor_ctrl_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        DEAD = 2'd1,
        RUN  = 2'd2
    } chan_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/motor_channel.sv
// One bridge channel: STOP/DEAD/RUN sequencing, dead-time counter, applied duty
// and registered leg drive. Optional soft start via MOTOR_SOFT_START_EN.
module motor_channel
    import motor_ctrl_pkg::*;
#(
    parameter int unsigned PWM_W       = 8,
    parameter int unsigned DEAD_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PWM_W-1:0] cnt,
    input  logic [PWM_W-1:0] speed,
    input  logic             dir,
    input  logic             estop,
    output logic             fwd,
    output logic             rev,
    output logic             running
);

    localparam int unsigned DW = $clog2(DEAD_CYCLES + 1);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES);

    chan_state_t      state_q, state_d;
    logic             dir_q, dir_d;
    logic [DW-1:0]    dead_q, dead_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic [PWM_W-1:0] entry_duty;
    logic             boundary;
    logic             pwm;
    logic             fwd_d, rev_d;

    // Duty applied on the first RUN cycle.
    always_comb begin
`ifdef MOTOR_SOFT_START_EN
        entry_duty = PWM_W'(1);
`else
        entry_duty = speed;
`endif
    end

    // Next state, dead counter, applied duty and leg levels.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        dead_d   = dead_q;
        duty_d   = duty_q;
        fwd_d    = 1'b0;
        rev_d    = 1'b0;
        boundary = (cnt == '0);

        if (boundary) begin
`ifdef MOTOR_SOFT_START_EN
            if (speed > duty_q) duty_d = duty_q + PWM_W'(1);
            else                duty_d = speed;
`else
            duty_d = speed;
`endif
        end

        case (state_q)
            STOP: begin
                if (speed != '0 && !estop) begin
                    state_d = RUN;
                    dir_d   = dir;
                    duty_d  = entry_duty;
                end
            end
            RUN: begin
                if (estop || speed == '0 || dir != dir_q) begin
                    state_d = DEAD;
                    dead_d  = DEAD_LOAD;
                end
            end
            DEAD: begin
                if (dead_q == '0) begin
                    if (estop || speed == '0) begin
                        state_d = STOP;
                    end else begin
                        state_d = RUN;
                        dir_d   = dir;
                        duty_d  = entry_duty;
                    end
                end else begin
                    dead_d = dead_q - DW'(1);
                end
            end
            default: state_d = STOP;
        endcase

        // Comparing against the next duty makes a boundary update visible at counter 0.
        pwm = (cnt < duty_d);
        if (state_q == RUN) begin
            fwd_d = pwm && (dir_q == DIR_FWD);
            rev_d = pwm && (dir_q == DIR_REV);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STOP;
            dir_q   <= DIR_FWD;
            dead_q  <= '0;
            duty_q  <= '0;
            fwd     <= 1'b0;
            rev     <= 1'b0;
            running <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            dead_q  <= dead_d;
            duty_q  <= duty_d;
            fwd     <= fwd_d;
            rev     <= rev_d;
            running <= (state_d == RUN);
        end
    end

endmodule

// File: rtl/motor_pair_ctrl.sv
// Two-motor H-bridge sequencer: input synchronisers, shared PWM counter and two
// channel instances. Soft start is enabled with MOTOR_SOFT_START_EN.
module motor_pair_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int unsigned PWM_W       = 8,
    parameter int unsigned DEAD_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PWM_W-1:0] a_speed,
    input  logic             a_dir,
    input  logic [PWM_W-1:0] b_speed,
    input  logic             b_dir,
    input  logic             estop,
    output logic             a_fwd,
    output logic             a_rev,
    output logic             b_fwd,
    output logic             b_rev,
    output logic             a_running,
    output logic             b_running
);

    localparam int unsigned CMD_W = 2 * PWM_W + 3;

    logic [CMD_W-1:0]                  cmd_raw;
    logic [CMD_W-1:0]                  cmd_sync;
    logic [SYNC_STAGES-1:0][CMD_W-1:0] sync_q;
    logic [PWM_W-1:0]                  cnt_q;
    logic [PWM_W-1:0]                  a_speed_s, b_speed_s;
    logic                              a_dir_s, b_dir_s, estop_s;

    assign cmd_raw  = {estop, b_dir, b_speed, a_dir, a_speed};
    assign cmd_sync = sync_q[SYNC_STAGES-1];
    assign {estop_s, b_dir_s, b_speed_s, a_dir_s, a_speed_s} = cmd_sync;

    // Multi-stage synchroniser for all command inputs and estop.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], cmd_raw};
    end

    // Shared free-running PWM counter; wraps every 2^PWM_W clocks.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_q + PWM_W'(1);
    end

    motor_channel #(.PWM_W(PWM_W), .DEAD_CYCLES(DEAD_CYCLES)) u_chan_a (
        .clk     (clk),
        .reset   (reset),
        .cnt     (cnt_q),
        .speed   (a_speed_s),
        .dir     (a_dir_s),
        .estop   (estop_s),
        .fwd     (a_fwd),
        .rev     (a_rev),
        .running (a_running)
    );

    motor_channel #(.PWM_W(PWM_W), .DEAD_CYCLES(DEAD_CYCLES)) u_chan_b (
        .clk     (clk),
        .reset   (reset),
        .cnt     (cnt_q),
        .speed   (b_speed_s),
        .dir     (b_dir_s),
        .estop   (estop_s),
        .fwd     (b_fwd),
        .rev     (b_rev),
        .running (b_running)
    );

endmodule
